instr_decode_issue: RTL and testbench

//  Decode/issue stage directly upstream of the 8x8 register bank. Accepts 16-bit instructions over a valid/ready

---
 rtl/instr_decode_issue.sv | 203 ++++++++++++++++++++
 tb/tb_instr_decode_issue.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_issue.sv
// Decode/issue stage feeding the 8x8 register bank.
// One-entry IR, registered OUT slot, per-register write-in-flight scoreboard.
module instr_decode_issue #(
  parameter int unsigned WB_LATENCY = 3
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [15:0] i_Instr,
  input  logic        i_InstrValid,
  output logic        o_InstrReady,
  output logic        o_IssueValid,
  input  logic        i_IssueReady,
  output logic [2:0]  o_AddrReg1,
  output logic [2:0]  o_AddrReg2,
  output logic [2:0]  o_AddrRegDest,
  output logic        o_WriteBack,
  output logic [3:0]  o_AluOp,
  output logic [7:0]  o_Imm,
  output logic        o_UseImm,
  output logic        o_Illegal,
  output logic        o_Halted
);

  typedef enum logic {S_RUN, S_HALT} state_e;

  state_e state_q, state_d;

  logic        ir_v_q, ir_v_d;
  logic [15:0] ir_q, ir_d;
  logic        out_v_q, out_v_d;
  logic [2:0]  a1_q, a2_q, rd_q;
  logic        wb_q, uimm_q;
  logic [3:0]  op_q;
  logic [7:0]  imm_q;
  logic        ill_q, ill_d;
  logic [7:0][2:0] cnt_q, cnt_d;

  logic [3:0] op;
  logic [2:0] rs1, rs2;
  logic       use1, use2;
  logic       dec_wb, dec_uimm;
  logic [2:0] dec_a1, dec_a2;
  logic [7:0] dec_imm;
  logic       is_nop, is_rsv, is_halt;
  logic       haz, out_free, drop_op;
  logic       leave, load_out, accept;
  logic       go_halt, issue_wr;

  assign op  = ir_q[15:12];
  assign rs1 = ir_q[8:6];
  assign rs2 = ir_q[5:3];

  always_comb begin
    use1     = 1'b0;
    use2     = 1'b0;
    dec_wb   = 1'b0;
    dec_uimm = 1'b0;
    dec_a1   = '0;
    dec_a2   = '0;
    dec_imm  = '0;
    is_nop   = 1'b0;
    is_rsv   = 1'b0;
    is_halt  = 1'b0;
    unique case (1'b1)
      (op inside {[4'd1:4'd5]}): begin
        use1   = 1'b1;
        use2   = 1'b1;
        dec_a1 = rs1;
        dec_a2 = rs2;
        dec_wb = 1'b1;
      end
      (op inside {4'd6, 4'd7}): begin
        use1   = 1'b1;
        dec_a1 = rs1;
        dec_a2 = rs2;
        dec_wb = 1'b1;
      end
      (op == 4'd8): begin
        dec_imm  = ir_q[7:0];
        dec_uimm = 1'b1;
        dec_wb   = 1'b1;
      end
      (op == 4'd9): begin
        use1     = 1'b1;
        dec_a1   = rs1;
        dec_imm  = {{2{ir_q[5]}}, ir_q[5:0]};
        dec_uimm = 1'b1;
        dec_wb   = 1'b1;
      end
      (op == 4'hA): begin
        use1   = 1'b1;
        dec_a1 = rs1;
        dec_wb = 1'b1;
      end
      (op inside {[4'hB:4'hE]}): is_rsv = 1'b1;
      (op == 4'hF): is_halt = 1'b1;
      default: is_nop = 1'b1;
    endcase
  end

  // RAW check: pending bank write, or the op sitting in OUT
  always_comb begin
    haz = 1'b0;
    if (use1 && (cnt_q[rs1] != 3'd0 ||
        (out_v_q && wb_q && rd_q == rs1)))
      haz = 1'b1;
    if (use2 && (cnt_q[rs2] != 3'd0 ||
        (out_v_q && wb_q && rd_q == rs2)))
      haz = 1'b1;
  end

  assign out_free = !out_v_q || i_IssueReady;
  assign drop_op  = is_nop || is_rsv || is_halt;
  assign leave    = ir_v_q && (drop_op || (!haz && out_free));
  assign load_out = ir_v_q && !drop_op && !haz && out_free;
  assign accept   = i_InstrValid && o_InstrReady;
  assign go_halt  = (state_q == S_RUN) && ir_v_q && is_halt;
  assign issue_wr = out_v_q && i_IssueReady && wb_q;

  always_ff @(posedge i_CLK) begin
    if (i_RST) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (go_halt) state_d = S_HALT;
  end

  always_comb begin
    o_Halted     = (state_q == S_HALT);
    o_InstrReady = (state_q == S_RUN) && (!ir_v_q || leave);
  end

  always_comb begin
    ir_v_d = ir_v_q;
    ir_d   = ir_q;
    if (leave) ir_v_d = 1'b0;
    if (accept) begin
      ir_v_d = 1'b1;
      ir_d   = i_Instr;
    end
    if (go_halt) ir_v_d = 1'b0;
    out_v_d = out_v_q;
    if (load_out)          out_v_d = 1'b1;
    else if (i_IssueReady) out_v_d = 1'b0;
    ill_d = ir_v_q && is_rsv;
  end

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      if (issue_wr && rd_q == 3'(r))
        cnt_d[r] = 3'(WB_LATENCY);
      else if (cnt_q[r] != 3'd0)
        cnt_d[r] = cnt_q[r] - 3'd1;
      else
        cnt_d[r] = 3'd0;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      ir_v_q  <= 1'b0;
      ir_q    <= '0;
      out_v_q <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      rd_q    <= '0;
      wb_q    <= 1'b0;
      op_q    <= '0;
      imm_q   <= '0;
      uimm_q  <= 1'b0;
    end else begin
      ir_v_q  <= ir_v_d;
      ir_q    <= ir_d;
      out_v_q <= out_v_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
      if (load_out) begin
        a1_q   <= dec_a1;
        a2_q   <= dec_a2;
        rd_q   <= ir_q[11:9];
        wb_q   <= dec_wb;
        op_q   <= op;
        imm_q  <= dec_imm;
        uimm_q <= dec_uimm;
      end
    end
  end

  assign o_IssueValid  = out_v_q;
  assign o_AddrReg1    = a1_q;
  assign o_AddrReg2    = a2_q;
  assign o_AddrRegDest = rd_q;
  assign o_WriteBack   = wb_q;
  assign o_AluOp       = op_q;
  assign o_Imm         = imm_q;
  assign o_UseImm      = uimm_q;
  assign o_Illegal     = ill_q;

endmodule

// File: tb/tb_instr_decode_issue.sv
// Bench for instr_decode_issue: directed cases plus random traffic
// checked against a rule-level model with register free times.
module tb_instr_decode_issue;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        i_RST;
  logic [15:0] i_Instr;
  logic        i_InstrValid;
  logic        o_InstrReady;
  logic        o_IssueValid;
  logic        i_IssueReady;
  logic [2:0]  o_AddrReg1, o_AddrReg2, o_AddrRegDest;
  logic        o_WriteBack;
  logic [3:0]  o_AluOp;
  logic [7:0]  o_Imm;
  logic        o_UseImm, o_Illegal, o_Halted;

  always #5 clk = ~clk;

  instr_decode_issue #(.WB_LATENCY(L)) dut (
    .i_CLK(clk),
    .i_RST(i_RST),
    .i_Instr(i_Instr),
    .i_InstrValid(i_InstrValid),
    .o_InstrReady(o_InstrReady),
    .o_IssueValid(o_IssueValid),
    .i_IssueReady(i_IssueReady),
    .o_AddrReg1(o_AddrReg1),
    .o_AddrReg2(o_AddrReg2),
    .o_AddrRegDest(o_AddrRegDest),
    .o_WriteBack(o_WriteBack),
    .o_AluOp(o_AluOp),
    .o_Imm(o_Imm),
    .o_UseImm(o_UseImm),
    .o_Illegal(o_Illegal),
    .o_Halted(o_Halted)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] a1;
    logic [2:0] a2;
    logic       wb;
    logic [7:0] imm;
    logic       ui;
    logic       u1;
    logic       u2;
  } dec_t;

  function automatic dec_t dec(input logic [15:0] w);
    dec_t d;
    logic signed [7:0] s;
    d = '0;
    d.op = w[15:12];
    d.rd = w[11:9];
    if (d.op >= 1 && d.op <= 10) d.wb = 1'b1;
    if (d.op inside {[1:7], 9, 10}) begin
      d.a1 = w[8:6];
      d.u1 = 1'b1;
    end
    if (d.op inside {[1:7]}) d.a2 = w[5:3];
    if (d.op inside {[1:5]}) d.u2 = 1'b1;
    if (d.op == 8) begin
      d.imm = w[7:0];
      d.ui = 1'b1;
    end
    if (d.op == 9) begin
      s = $signed(w[5:0]);
      d.imm = s;
      d.ui = 1'b1;
    end
    return d;
  endfunction

  // Model: register r is busy while edge count < free_at[r]
  bit          m_live = 1'b0;
  bit          m_run, m_ir_v, m_out_v, m_ill;
  logic [15:0] m_ir;
  dec_t        m_out;
  int          m_free_at[8];
  int          m_n = 0;

  function automatic bit busy(input logic [2:0] r);
    return (m_n < m_free_at[r]) ||
           (m_out_v && m_out.wb && m_out.rd == r);
  endfunction

  function automatic bit m_drop();
    return m_ir[15:12] == 0 || m_ir[15:12] >= 11;
  endfunction

  function automatic bit m_haz();
    dec_t d;
    d = dec(m_ir);
    return (d.u1 && busy(d.a1)) || (d.u2 && busy(d.a2));
  endfunction

  function automatic bit m_leaves();
    return m_ir_v && (m_drop() ||
           (!m_haz() && (!m_out_v || i_IssueReady)));
  endfunction

  function automatic bit m_ready();
    return m_run && (!m_ir_v || m_leaves());
  endfunction

  task automatic model_step();
    bit acc, lv, iss, halting, drop;
    logic [3:0] op;
    if (i_RST) begin
      m_live  = 1'b1;
      m_run   = 1'b1;
      m_ir_v  = 1'b0;
      m_ir    = '0;
      m_out_v = 1'b0;
      m_out   = '0;
      m_ill   = 1'b0;
      foreach (m_free_at[r]) m_free_at[r] = 0;
    end else if (m_live) begin
      op      = m_ir[15:12];
      acc     = i_InstrValid && m_ready();
      lv      = m_leaves();
      drop    = m_ir_v && m_drop();
      iss     = lv && !m_drop();
      halting = m_ir_v && op == 15;
      if (m_out_v && i_IssueReady && m_out.wb)
        m_free_at[m_out.rd] = m_n + 1 + L;
      m_ill = drop && (op inside {[11:14]});
      if (iss) begin
        m_out_v = 1'b1;
        m_out   = dec(m_ir);
      end else if (i_IssueReady) begin
        m_out_v = 1'b0;
      end
      if (lv) m_ir_v = 1'b0;
      if (acc) begin
        m_ir_v = 1'b1;
        m_ir   = i_Instr;
      end
      if (halting) begin
        m_run  = 1'b0;
        m_ir_v = 1'b0;
      end
    end
    m_n++;
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("ready", o_InstrReady, m_ready());
      chk("ivalid", o_IssueValid, m_out_v);
      chk("illegal", o_Illegal, m_ill);
      chk("halted", o_Halted, !m_run);
      if (m_out_v) begin
        chk("addr1", o_AddrReg1, m_out.a1);
        chk("addr2", o_AddrReg2, m_out.a2);
        chk("dest", o_AddrRegDest, m_out.rd);
        chk("wb", o_WriteBack, m_out.wb);
        chk("aluop", o_AluOp, m_out.op);
        chk("imm", o_Imm, m_out.imm);
        chk("useimm", o_UseImm, m_out.ui);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    i_InstrValid = 1'b0;
    i_IssueReady = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic send1(input logic [15:0] w);
    i_Instr = w;
    i_InstrValid = 1'b1;
    cyc();
    i_InstrValid = 1'b0;
    cyc();
    @(negedge clk);
  endtask

  function automatic logic [15:0] rnd_instr();
    logic [15:0] w;
    int r;
    w = 16'($urandom);
    w[11] = 1'b0;
    w[8] = 1'b0;
    r = $urandom_range(0, 199);
    if (r < 2)       w[15:12] = 4'hF;
    else if (r < 14) w[15:12] = 4'($urandom_range(11, 14));
    else if (r < 24) w[15:12] = 4'h0;
    else             w[15:12] = 4'($urandom_range(1, 10));
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, idx, ill_cnt, iss_cnt, last_op, hcnt;
    int got[$];
    logic [15:0] st[4];
    logic [15:0] sq[3];

    i_RST = 1'b1;
    i_Instr = '0;
    i_InstrValid = 1'b0;
    i_IssueReady = 1'b1;
    cyc();
    cyc();
    i_RST = 1'b0;
    @(negedge clk);
    chk("rst_ready", o_InstrReady, 1);
    chk("rst_valid", o_IssueValid, 0);
    chk("rst_halted", o_Halted, 0);
    chk("rst_dest", o_AddrRegDest, 0);
    chk("rst_imm", o_Imm, 0);

    send1(16'h1650);
    chk("add_valid", o_IssueValid, 1);
    chk("add_a1", o_AddrReg1, 1);
    chk("add_a2", o_AddrReg2, 2);
    chk("add_dest", o_AddrRegDest, 3);
    chk("add_wb", o_WriteBack, 1);
    chk("add_op", o_AluOp, 1);
    idle(8);

    i_Instr = 16'h1650;
    i_InstrValid = 1'b1;
    cyc();
    i_Instr = 16'h28C8;
    cyc();
    i_InstrValid = 1'b0;
    cyc();
    @(negedge clk);
    chk("sub_stall_ready", o_InstrReady, 0);
    chk("sub_stall_valid", o_IssueValid, 0);
    k = 0;
    while (!(o_IssueValid && o_AluOp == 4'd2) && k < 20) begin
      cyc();
      k++;
      @(negedge clk);
    end
    chk("sub_gap", k, 4);
    chk("sub_dest", o_AddrRegDest, 4);
    chk("sub_a1", o_AddrReg1, 3);
    idle(8);

    send1(16'h8AA7);
    chk("ldi_dest", o_AddrRegDest, 5);
    chk("ldi_imm", o_Imm, 8'hA7);
    chk("ldi_ui", o_UseImm, 1);
    chk("ldi_a1", o_AddrReg1, 0);
    chk("ldi_a2", o_AddrReg2, 0);
    send1(16'h94BD);
    chk("addi_imm", o_Imm, 8'hFD);
    chk("addi_dest", o_AddrRegDest, 2);
    chk("addi_a1", o_AddrReg1, 2);
    chk("addi_a2", o_AddrReg2, 0);
    idle(8);

    st = '{16'h1650, 16'h1850, 16'h1A50, 16'h1C50};
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      i_InstrValid = (idx < 4);
      i_Instr = st[idx < 4 ? idx : 3];
      i_IssueReady = (c >= 5);
      @(negedge clk);
      if (c == 4) begin
        chk("bp_ready", o_InstrReady, 0);
        chk("bp_valid", o_IssueValid, 1);
        chk("bp_dest", o_AddrRegDest, 3);
      end
      if (i_InstrValid && o_InstrReady) idx++;
      if (o_IssueValid && i_IssueReady)
        got.push_back(int'(o_AddrRegDest));
      cyc();
    end
    chk("bp_count", got.size(), 4);
    foreach (got[i]) chk("bp_order", got[i], 3 + i);
    idle(8);

    sq = '{16'hB000, 16'h0000, 16'h1650};
    idx = 0;
    ill_cnt = 0;
    iss_cnt = 0;
    last_op = 0;
    for (int c = 0; c < 20; c++) begin
      i_InstrValid = (idx < 3);
      i_Instr = sq[idx < 3 ? idx : 2];
      @(negedge clk);
      if (o_Illegal) ill_cnt++;
      if (o_IssueValid && i_IssueReady) begin
        iss_cnt++;
        last_op = int'(o_AluOp);
      end
      if (i_InstrValid && o_InstrReady) idx++;
      cyc();
    end
    chk("ill_pulses", ill_cnt, 1);
    chk("ill_issues", iss_cnt, 1);
    chk("ill_lastop", last_op, 1);
    idle(8);

    i_Instr = 16'hF000;
    i_InstrValid = 1'b1;
    cyc();
    i_Instr = 16'h1650;
    cyc();
    @(negedge clk);
    chk("halt_flag", o_Halted, 1);
    chk("halt_ready", o_InstrReady, 0);
    hcnt = 0;
    repeat (10) begin
      cyc();
      @(negedge clk);
      if (o_Halted && !o_InstrReady && !o_IssueValid) hcnt++;
    end
    chk("halt_hold", hcnt, 10);
    i_RST = 1'b1;
    cyc();
    i_RST = 1'b0;
    i_InstrValid = 1'b0;
    @(negedge clk);
    chk("hrst_ready", o_InstrReady, 1);
    chk("hrst_halted", o_Halted, 0);
    chk("hrst_valid", o_IssueValid, 0);
    chk("hrst_ill", o_Illegal, 0);
    chk("hrst_fields",
        {o_AddrReg1, o_AddrReg2, o_AddrRegDest, o_WriteBack,
         o_AluOp, o_Imm, o_UseImm}, 0);

    for (int c = 0; c < 4000; c++) begin
      i_RST = ($urandom_range(0, 99) == 0);
      i_InstrValid = ($urandom_range(0, 3) != 0);
      i_IssueReady = ($urandom_range(0, 3) != 0);
      i_Instr = rnd_instr();
      cyc();
    end
    i_RST = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
